seg_display_seq: RTL

Parametrised successor to the team's 7-segment display driver. It captures a bank of N_VALUES unsigned values on a single load strobe and presents them one after another on a DIGITS-wide multiplexed common-anode 7-segment display, each for a programmable dwell time, then signals completion. Binary-to-decimal conversion is done sequentially (shift-and-add-3), replacing combinational divide/modulo. It adds leading-zero blanking, overflow indication, a dwell hold, and a busy/done handshake. It sits between the compute result registers and the board display pins.

---
 rtl/seg_display_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seg_display_seq.sv
// Captures N_VALUES values, converts each to BCD serially (VAL_W cycles), shows each for DWELL_CYCLES on a scanned display.
// Segment/anode outputs are registered one cycle behind the scan and display state.
module seg_display_seq #(
  parameter int N_VALUES       = 8,
  parameter int VAL_W          = 8,
  parameter int DIGITS         = 4,
  parameter int DWELL_CYCLES   = 100000000,
  parameter int REFRESH_CYCLES = 262144,
  parameter int BLANK_LZ       = 1
) (
  input  logic                                               clock_100Mhz,
  input  logic                                               reset_n,
  input  logic                                               load_i,
  input  logic [N_VALUES*VAL_W-1:0]                          values_i,
  input  logic                                               hold_i,
  output logic                                               busy_o,
  output logic                                               is_done_o,
  output logic [((N_VALUES > 1) ? $clog2(N_VALUES) : 1)-1:0] idx_o,
  output logic [DIGITS-1:0]                                  anode_o,
  output logic [6:0]                                         seg_o
);

  localparam int IW         = (N_VALUES > 1) ? $clog2(N_VALUES) : 1;
  localparam int BCD_DIGITS = (VAL_W + 4) / 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int NDIG       = (DIGITS > BCD_DIGITS) ? DIGITS : BCD_DIGITS;
  localparam int BW         = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int DWW        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int RW         = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int SW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHOW, S_DONE} state_t;

  state_t                    state_q;
  logic [IW-1:0]             idx_q;
  logic [N_VALUES*VAL_W-1:0] vals_q;
  logic [VAL_W-1:0]          shift_q;
  logic [BCD_W-1:0]          bcd_q;
  logic [BW-1:0]             bit_q;
  logic [DWW-1:0]            dwell_q;
  logic [BCD_W-1:0]          disp_q;
  logic                      disp_vld_q;
  logic                      busy_q;
  logic                      done_q;
  logic [RW-1:0]             rcnt_q;
  logic [SW-1:0]             sdig_q;
  logic [DIGITS-1:0]         anode_q;
  logic [6:0]                seg_q;

  logic [BCD_W-1:0]          bcd_adj;
  logic [BCD_W-1:0]          bcd_d;
  logic [VAL_W-1:0]          shift_d;
  logic [IW-1:0]             idx_d;
  logic [NDIG*4-1:0]         disp_ext;
  logic                      ovf;
  logic [SW-1:0]             msd;
  logic [3:0]                cur;
  logic [6:0]                seg_d;
  logic [DIGITS-1:0]         anode_d;

  // One shift-and-add-3 step: correct digits >= 5, then shift the next binary bit in.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
  end

  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge clock_100Mhz) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      vals_q     <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      bit_q      <= '0;
      dwell_q    <= '0;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (load_i) begin
            vals_q  <= values_i;
            idx_q   <= '0;
            shift_q <= values_i[VAL_W-1:0];
            bcd_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          shift_q <= shift_d;
          bcd_q   <= bcd_d;
          bit_q   <= bit_q + 1'b1;
          if (bit_q == BW'(VAL_W - 1)) begin
            disp_q     <= bcd_d;
            disp_vld_q <= 1'b1;
            dwell_q    <= '0;
            state_q    <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (!hold_i) begin
            if (dwell_q == DWW'(DWELL_CYCLES - 1)) begin
              if (idx_q == IW'(N_VALUES - 1)) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_d;
                shift_q <= vals_q[int'(idx_d)*VAL_W +: VAL_W];
                bcd_q   <= '0;
                bit_q   <= '0;
                state_q <= S_CONV;
              end
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    disp_ext              = '0;
    disp_ext[BCD_W-1:0]   = disp_q;
    ovf = 1'b0;
    for (int i = DIGITS; i < NDIG; i++) begin
      if (disp_ext[i*4 +: 4] != 4'd0) ovf = 1'b1;
    end
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_ext[i*4 +: 4] != 4'd0) msd = SW'(i);
    end
    cur = disp_ext[int'(sdig_q)*4 +: 4];
    case (cur)
      4'd0:    seg_d = 7'b0000001;
      4'd1:    seg_d = 7'b1001111;
      4'd2:    seg_d = 7'b0010010;
      4'd3:    seg_d = 7'b0000110;
      4'd4:    seg_d = 7'b1001100;
      4'd5:    seg_d = 7'b0100100;
      4'd6:    seg_d = 7'b0100000;
      4'd7:    seg_d = 7'b0001111;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0000100;
      default: seg_d = 7'b1111111;
    endcase
    // Overflow dash wins over blanking; msd stays 0 for a zero value so digit 0 still lights.
    if (ovf) seg_d = 7'b1111110;
    else if (BLANK_LZ != 0 && sdig_q > msd) seg_d = 7'b1111111;
    anode_d = '1;
    if (disp_vld_q) anode_d[sdig_q] = 1'b0;
    else seg_d = 7'b1111111;
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset_n) begin
      rcnt_q  <= '0;
      sdig_q  <= '0;
      anode_q <= '1;
      seg_q   <= 7'b1111111;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
      if (rcnt_q == RW'(REFRESH_CYCLES - 1)) begin
        rcnt_q <= '0;
        sdig_q <= (sdig_q == SW'(DIGITS - 1)) ? '0 : sdig_q + 1'b1;
      end else begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  assign busy_o    = busy_q;
  assign is_done_o = done_q;
  assign idx_o     = idx_q;
  assign anode_o   = anode_q;
  assign seg_o     = seg_q;

endmodule
